load_return_queue: RTL and testbench

- Parametrised successor to the single-slot MEM2 load return path.
- Tracks up to DEPTH outstanding data-sram loads in order and buffers each data_ok response, even while writeback stalls.
- Performs byte/half/word alignment, including a true lwl/lwr merge with the old rt value.
- Flush discards all queued and in-flight loads. Responses that are still returning are counted and dropped.
- Sits between the data-sram response channel and the writeback stage.

---
 rtl/load_return_queue_pkg.sv | 25 ++
 rtl/load_align.sv | 58 +++++
 rtl/load_return_queue.sv | 146 ++++++++++++++
 tb/tb_load_return_queue.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_return_queue_pkg.sv
// Shared definitions for the load return queue.
// Holds the 3-bit load type encodings, the per-load metadata record and its
// flattened width, used by load_return_queue and load_align.
package load_return_queue_pkg;

  localparam logic [2:0] LD_LW  = 3'd0;
  localparam logic [2:0] LD_LB  = 3'd1;
  localparam logic [2:0] LD_LBU = 3'd2;
  localparam logic [2:0] LD_LH  = 3'd3;
  localparam logic [2:0] LD_LHU = 3'd4;
  localparam logic [2:0] LD_LWL = 3'd5;
  localparam logic [2:0] LD_LWR = 3'd6;

  // ld_type + low_addr + dest + rt_old + pc
  localparam int META_W = 3 + 2 + 5 + 32 + 32;

  typedef struct packed {
    logic [2:0]  ld_type;
    logic [1:0]  low_addr;
    logic [4:0]  dest;
    logic [31:0] rt_old;
    logic [31:0] pc;
  } meta_t;

endpackage

// File: rtl/load_align.sv
// Combinational load result alignment.
// Ports:
//   ld_type_i  [2:0]  load type (LD_* encodings)
//   low_addr_i [1:0]  byte address bits [1:0]
//   rdata_i    [31:0] raw word returned by the data sram
//   rt_old_i   [31:0] previous rt value, merged in for lwl/lwr
//   wdata_o    [31:0] aligned / merged writeback value
module load_align
  import load_return_queue_pkg::*;
(
  input  logic [2:0]  ld_type_i,
  input  logic [1:0]  low_addr_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] rt_old_i,
  output logic [31:0] wdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (low_addr_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    // Halfword selection only looks at bit 1; bit 0 is ignored.
    half_sel = low_addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    wdata_o = rdata_i;
    case (ld_type_i)
      LD_LB:  wdata_o = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU: wdata_o = {24'h000000, byte_sel};
      LD_LH:  wdata_o = {{16{half_sel[15]}}, half_sel};
      LD_LHU: wdata_o = {16'h0000, half_sel};
      LD_LWL: begin
        case (low_addr_i)
          2'd0:    wdata_o = {rdata_i[7:0],  rt_old_i[23:0]};
          2'd1:    wdata_o = {rdata_i[15:0], rt_old_i[15:0]};
          2'd2:    wdata_o = {rdata_i[23:0], rt_old_i[7:0]};
          default: wdata_o = rdata_i;
        endcase
      end
      LD_LWR: begin
        case (low_addr_i)
          2'd0:    wdata_o = rdata_i;
          2'd1:    wdata_o = {rt_old_i[31:24], rdata_i[31:8]};
          2'd2:    wdata_o = {rt_old_i[31:16], rdata_i[31:16]};
          default: wdata_o = {rt_old_i[31:8],  rdata_i[31:24]};
        endcase
      end
      default: wdata_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_return_queue.sv
// In-order load return queue between the data-sram response channel and
// writeback. Tracks up to DEPTH outstanding loads, buffers responses while
// writeback stalls, aligns results, and drops responses owed to flushed loads.
// Ports:
//   clk, reset (async, active-high)
//   req_*            load issue side (fire, type, low addr, dest, old rt, pc)
//   req_allowin      a new load may be issued
//   data_sram_*      response channel (data_ok, rdata)
//   flush            discard every tracked load
//   out_*            writeback side (valid/ready, dest, wdata, pc)
//   outstanding      tracked loads plus responses still owed to flushed loads
//   proto_err        sticky: illegal issue or response with nothing owed
module load_return_queue
  import load_return_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter bit BYPASS = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_fire,
  input  logic [2:0]                 req_ld_type,
  input  logic [1:0]                 req_low_addr,
  input  logic [4:0]                 req_dest,
  input  logic [31:0]                req_rt_old,
  input  logic [31:0]                req_pc,
  output logic                       req_allowin,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [4:0]                 out_dest,
  output logic [31:0]                out_wdata,
  output logic [31:0]                out_pc,
  output logic [$clog2(DEPTH):0]     outstanding,
  output logic                       proto_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] meta_cnt_q, meta_cnt_d;
  logic [CW-1:0] data_cnt_q, data_cnt_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic          proto_err_q, proto_err_d;

  meta_t       meta_mem [DEPTH];
  logic [31:0] data_mem [DEPTH];

  logic [CW-1:0] inflight;
  logic [CW:0]   occupancy;
  logic          req_ok, rsp_drop, rsp_take, rsp_err;
  logic          bypass, pop, pop_buf, push_data;
  logic [PW-1:0] data_wr_idx;
  meta_t         head_meta;
  logic [31:0]   head_data, aligned;

  // Responses return in order, so the data for a meta slot lands at
  // rd_ptr + data_cnt; the data FIFO shares the meta read pointer.
  assign data_wr_idx = rd_ptr_q + data_cnt_q[PW-1:0];
  assign head_meta   = meta_mem[rd_ptr_q];
  assign head_data   = (data_cnt_q != '0) ? data_mem[rd_ptr_q] : data_sram_rdata;

  load_align u_align (
    .ld_type_i  (head_meta.ld_type),
    .low_addr_i (head_meta.low_addr),
    .rdata_i    (head_data),
    .rt_old_i   (head_meta.rt_old),
    .wdata_o    (aligned)
  );

  always_comb begin
    inflight    = meta_cnt_q - data_cnt_q;
    occupancy   = {1'b0, meta_cnt_q} + {1'b0, drop_cnt_q};
    req_allowin = occupancy < (CW+1)'(DEPTH);
    outstanding = occupancy[CW-1:0];
    req_ok      = req_fire && req_allowin;

    rsp_drop = data_sram_data_ok && (drop_cnt_q != '0);
    rsp_take = data_sram_data_ok && (drop_cnt_q == '0) && (inflight != '0);
    rsp_err  = data_sram_data_ok && (drop_cnt_q == '0) && (inflight == '0);

    bypass    = BYPASS && (data_cnt_q == '0) && rsp_take;
    out_valid = !flush && ((data_cnt_q != '0) || bypass);
    pop       = out_valid && out_ready;
    // A bypassed response that leaves immediately is never buffered.
    pop_buf   = pop && (data_cnt_q != '0);
    push_data = rsp_take && !(bypass && pop);

    out_dest  = out_valid ? head_meta.dest : 5'd0;
    out_wdata = out_valid ? aligned        : 32'd0;
    out_pc    = out_valid ? head_meta.pc   : 32'd0;
    proto_err = proto_err_q;

    proto_err_d = proto_err_q || rsp_err || (req_fire && !req_allowin);
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    meta_cnt_d  = meta_cnt_q;
    data_cnt_d  = data_cnt_q;
    drop_cnt_d  = drop_cnt_q - CW'(rsp_drop);

    if (flush) begin
      // Everything still owed (in flight, just issued) becomes a drop debt.
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      meta_cnt_d = '0;
      data_cnt_d = '0;
      drop_cnt_d = drop_cnt_q - CW'(rsp_drop) + inflight + CW'(req_ok) - CW'(rsp_take);
    end else begin
      if (req_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_d = rd_ptr_q + 1'b1;
      meta_cnt_d = meta_cnt_q + CW'(req_ok) - CW'(pop);
      data_cnt_d = data_cnt_q + CW'(push_data) - CW'(pop_buf);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      meta_cnt_q  <= '0;
      data_cnt_q  <= '0;
      drop_cnt_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      meta_cnt_q  <= meta_cnt_d;
      data_cnt_q  <= data_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Storage arrays carry no reset; validity is tracked by the counters.
  always_ff @(posedge clk) begin
    if (req_ok) begin
      meta_mem[wr_ptr_q] <= '{ld_type: req_ld_type, low_addr: req_low_addr,
                              dest: req_dest, rt_old: req_rt_old, pc: req_pc};
    end
    if (push_data) data_mem[data_wr_idx] <= data_sram_rdata;
  end

endmodule

// File: tb/tb_load_return_queue.sv
module tb_load_return_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_fire;
  logic [2:0]  req_ld_type;
  logic [1:0]  req_low_addr;
  logic [4:0]  req_dest;
  logic [31:0] req_rt_old;
  logic [31:0] req_pc;
  logic        req_allowin;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_dest;
  logic [31:0] out_wdata;
  logic [31:0] out_pc;
  logic [2:0]  outstanding;
  logic        proto_err;

  int checks   = 0;
  int failures = 0;

  load_return_queue #(.DEPTH(DEPTH), .BYPASS(1'b1)) dut (
    .clk               (clk),
    .reset             (reset),
    .req_fire          (req_fire),
    .req_ld_type       (req_ld_type),
    .req_low_addr      (req_low_addr),
    .req_dest          (req_dest),
    .req_rt_old        (req_rt_old),
    .req_pc            (req_pc),
    .req_allowin       (req_allowin),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .flush             (flush),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_dest          (out_dest),
    .out_wdata         (out_wdata),
    .out_pc            (out_pc),
    .outstanding       (outstanding),
    .proto_err         (proto_err)
  );

  always #5 clk = ~clk;

  // Reference model: list of unretired loads, list of arrived data words,
  // count of responses owed to flushed loads, sticky error flag.
  typedef struct {
    logic [2:0]  t;
    logic [1:0]  a;
    logic [4:0]  d;
    logic [31:0] rt;
    logic [31:0] pc;
  } ld_t;

  ld_t         mq[$];
  logic [31:0] dq[$];
  int          drop;
  bit          perr;

  function automatic logic [31:0] ref_align(logic [2:0] t, logic [1:0] a,
                                            logic [31:0] r, logic [31:0] rt);
    int          sh;
    logic [31:0] m, x;
    case (t)
      3'd1, 3'd2: begin
        x = (r >> (8 * a)) & 32'hFF;
        if (t == 3'd1 && x[7]) x = x | 32'hFFFF_FF00;
      end
      3'd3, 3'd4: begin
        x = (r >> (16 * a[1])) & 32'hFFFF;
        if (t == 3'd3 && x[15]) x = x | 32'hFFFF_0000;
      end
      3'd5: begin
        sh = 8 * (3 - a);
        m  = (32'h1 << sh) - 32'h1;
        x  = (r << sh) | (rt & m);
      end
      3'd6: begin
        sh = 8 * a;
        m  = 32'hFFFF_FFFF >> sh;
        x  = (r >> sh) | (rt & ~m);
      end
      default: x = r;
    endcase
    return x;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    req_fire = 0; req_ld_type = 0; req_low_addr = 0; req_dest = 0;
    req_rt_old = 0; req_pc = 0; data_sram_data_ok = 0; data_sram_rdata = 0;
    flush = 0;
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, ".out_valid"},   32'(out_valid),   32'd0);
    chk({tag, ".req_allowin"}, 32'(req_allowin), 32'd1);
    chk({tag, ".outstanding"}, 32'(outstanding), 32'd0);
    chk({tag, ".proto_err"},   32'(proto_err),   32'd0);
    chk({tag, ".out_dest"},    32'(out_dest),    32'd0);
    chk({tag, ".out_wdata"},   out_wdata,        32'd0);
    chk({tag, ".out_pc"},      out_pc,           32'd0);
  endtask

  // Called just after a falling edge with inputs already applied: checks the
  // DUT against the model, then advances the model across the rising edge.
  task automatic cycle();
    int   infl;
    bit   byp, ev, req_ok;
    ld_t  h;
    logic [31:0] hd;
    #1;
    infl = mq.size() - dq.size();
    byp  = (dq.size() == 0) && (drop == 0) && (infl > 0) && data_sram_data_ok;
    ev   = !flush && ((dq.size() > 0) || byp);
    chk("out_valid",   32'(out_valid),   32'(ev));
    chk("req_allowin", 32'(req_allowin), 32'((mq.size() + drop) < DEPTH));
    chk("outstanding", 32'(outstanding), 32'(mq.size() + drop));
    chk("proto_err",   32'(proto_err),   32'(perr));
    if (ev) begin
      h  = mq[0];
      hd = (dq.size() > 0) ? dq[0] : data_sram_rdata;
      chk("out_wdata", out_wdata, ref_align(h.t, h.a, hd, h.rt));
      chk("out_dest",  32'(out_dest), 32'(h.d));
      chk("out_pc",    out_pc, h.pc);
    end else begin
      chk("out_wdata_idle", out_wdata, 32'd0);
    end
    @(posedge clk);
    req_ok = req_fire && ((mq.size() + drop) < DEPTH);
    if (req_fire && !req_ok) perr = 1;
    if (data_sram_data_ok) begin
      if (drop > 0) drop--;
      else if (infl > 0) dq.push_back(data_sram_rdata);
      else perr = 1;
    end
    if (req_ok) mq.push_back('{req_ld_type, req_low_addr, req_dest, req_rt_old, req_pc});
    if (flush) begin
      drop += mq.size() - dq.size();
      mq.delete();
      dq.delete();
    end else if (ev && out_ready) begin
      void'(mq.pop_front());
      void'(dq.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic issue(logic [2:0] t, logic [1:0] a, logic [4:0] d,
                       logic [31:0] rt, logic [31:0] pc);
    req_fire = 1; req_ld_type = t; req_low_addr = a; req_dest = d;
    req_rt_old = rt; req_pc = pc;
    cycle();
    req_fire = 0;
  endtask

  task automatic respond(logic [31:0] r);
    data_sram_data_ok = 1; data_sram_rdata = r;
    cycle();
    data_sram_data_ok = 0;
  endtask

  task automatic respond_expect(logic [31:0] r, logic [31:0] exp, string tag);
    data_sram_data_ok = 1; data_sram_rdata = r;
    #1;
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".wdata"}, out_wdata, exp);
    cycle();
    data_sram_data_ok = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    #1;
    mq.delete(); dq.delete(); drop = 0; perr = 0;
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    idle_inputs();
    out_ready = 1;
    drop = 0; perr = 0;
    reset = 1;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 0;

    // Alignment through the bypass path: empty queue, ready writeback.
    issue(3'd1, 2'd1, 5'd3, 32'h0, 32'h0000_0100);
    respond_expect(32'h1234_80FF, 32'hFFFF_FF80, "lb_a1");
    chk("bypass_drain", 32'(outstanding), 32'd0);
    issue(3'd4, 2'd2, 5'd4, 32'h0, 32'h0000_0104);
    respond_expect(32'h1234_80FF, 32'h0000_1234, "lhu_a2");
    issue(3'd5, 2'd1, 5'd5, 32'hAABB_CCDD, 32'h0000_0108);
    respond_expect(32'h1122_3344, 32'h3344_CCDD, "lwl_a1");
    issue(3'd6, 2'd2, 5'd6, 32'hAABB_CCDD, 32'h0000_010C);
    respond_expect(32'h1122_3344, 32'hAABB_1122, "lwr_a2");

    // Fill to DEPTH with writeback stalled, then drain in order.
    out_ready = 0;
    for (int i = 0; i < DEPTH; i++)
      issue(3'(i % 7), 2'(i), 5'(10 + i), $urandom, 32'h200 + 32'(4 * i));
    chk("full_allowin", 32'(req_allowin), 32'd0);
    for (int i = 0; i < DEPTH; i++) respond($urandom);
    out_ready = 1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      chk("drain_pc", out_pc, 32'h200 + 32'(4 * i));
      cycle();
    end
    chk("drained", 32'(outstanding), 32'd0);

    // Flush with 2 in flight, 1 buffered and a concurrent issue.
    out_ready = 0;
    for (int i = 0; i < 3; i++) issue(3'd0, 2'd0, 5'd7, 32'h0, 32'h300 + 32'(4 * i));
    respond(32'hDEAD_0001);
    flush = 1;
    issue(3'd0, 2'd0, 5'd8, 32'h0, 32'h30C);
    flush = 0;
    chk("flush_drop", 32'(outstanding), 32'd3);
    out_ready = 1;
    for (int i = 0; i < 3; i++) respond($urandom);
    issue(3'd0, 2'd0, 5'd9, 32'h0, 32'h400);
    respond_expect(32'hCAFE_F00D, 32'hCAFE_F00D, "post_flush");

    // Response with nothing outstanding sets a sticky error.
    respond(32'h5555_5555);
    chk("proto_err_set", 32'(proto_err), 32'd1);
    cycle();
    chk("proto_err_sticky", 32'(proto_err), 32'd1);

    // Asynchronous reset mid-burst, checked before any clock edge.
    do_reset();
    out_ready = 0;
    issue(3'd0, 2'd0, 5'd1, 32'h0, 32'h500);
    issue(3'd0, 2'd0, 5'd2, 32'h0, 32'h504);
    respond(32'h1111_2222);
    reset = 1;
    #1;
    check_reset_outputs("async_reset");
    mq.delete(); dq.delete(); drop = 0; perr = 0;
    @(negedge clk);
    reset = 0;
    out_ready = 1;
    respond(32'h7777_7777);
    chk("late_rsp_err", 32'(proto_err), 32'd1);

    // Randomized legal traffic against the model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      req_fire          = ($urandom_range(0, 2) == 0) && ((mq.size() + drop) < DEPTH);
      req_ld_type       = 3'($urandom_range(0, 7));
      req_low_addr      = 2'($urandom);
      req_dest          = 5'($urandom);
      req_rt_old        = $urandom;
      req_pc            = $urandom;
      data_sram_data_ok = ((mq.size() - dq.size() + drop) > 0) && ($urandom_range(0, 1) == 1);
      data_sram_rdata   = $urandom;
      out_ready         = ($urandom_range(0, 3) != 0);
      flush             = ($urandom_range(0, 39) == 0);
      cycle();
    end
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
